// File: rtl/rs_station_if.sv
// rs_station_if: dispatch, CDB snoop and ALU issue bundle of the reservation station
interface rs_station_if #(parameter int ROB_W = 4);
    logic             disp_flag;
    logic [5:0]       disp_code;
    logic [31:0]      disp_pc;
    logic [31:0]      disp_imm;
    logic [ROB_W-1:0] disp_rob_id;
    logic             disp_q1_busy;
    logic [ROB_W-1:0] disp_q1;
    logic [31:0]      disp_v1;
    logic             disp_q2_busy;
    logic [ROB_W-1:0] disp_q2;
    logic [31:0]      disp_v2;
    logic             rs_full;
    logic             alu_cdb_flag;
    logic [ROB_W-1:0] alu_cdb_rob_id;
    logic [31:0]      alu_cdb_val;
    logic             lsb_cdb_flag;
    logic [ROB_W-1:0] lsb_cdb_rob_id;
    logic [31:0]      lsb_cdb_val;
    logic             ex_flag;
    logic [31:0]      ex_v1;
    logic [31:0]      ex_v2;
    logic [31:0]      ex_a;
    logic [31:0]      ex_pc;
    logic [5:0]       ex_code;
    logic [ROB_W-1:0] ex_rob_id;

    modport master(
        output disp_flag, disp_code, disp_pc, disp_imm, disp_rob_id,
               disp_q1_busy, disp_q1, disp_v1, disp_q2_busy, disp_q2, disp_v2,
               alu_cdb_flag, alu_cdb_rob_id, alu_cdb_val,
               lsb_cdb_flag, lsb_cdb_rob_id, lsb_cdb_val,
        input  rs_full, ex_flag, ex_v1, ex_v2, ex_a, ex_pc, ex_code, ex_rob_id
    );

    modport slave(
        input  disp_flag, disp_code, disp_pc, disp_imm, disp_rob_id,
               disp_q1_busy, disp_q1, disp_v1, disp_q2_busy, disp_q2, disp_v2,
               alu_cdb_flag, alu_cdb_rob_id, alu_cdb_val,
               lsb_cdb_flag, lsb_cdb_rob_id, lsb_cdb_val,
        output rs_full, ex_flag, ex_v1, ex_v2, ex_a, ex_pc, ex_code, ex_rob_id
    );
endinterface

// File: rtl/rs_station.sv
// rs_station: buffers ALU/branch ops, wakes operands from both CDBs and issues one ready op per cycle
module rs_station #(
    parameter int RS_SIZE = 16,
    parameter int IDX_W   = 4,
    parameter int ROB_W   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rdy,
    input  logic        clr,
    rs_station_if.slave bus
);
    logic [RS_SIZE-1:0] busy, q1_busy, q2_busy, ready, free;
    logic [ROB_W-1:0]   q1 [RS_SIZE];
    logic [ROB_W-1:0]   q2 [RS_SIZE];
    logic [ROB_W-1:0]   rob_id [RS_SIZE];
    logic [31:0]        v1 [RS_SIZE];
    logic [31:0]        v2 [RS_SIZE];
    logic [31:0]        a [RS_SIZE];
    logic [31:0]        pc [RS_SIZE];
    logic [5:0]         code [RS_SIZE];
    logic [IDX_W:0]     cnt;
    logic [IDX_W-1:0]   iss_idx, free_idx;
    logic               iss_ok, disp_ok;
    logic               alu_f, lsb_f;
    logic [ROB_W-1:0]   alu_t, lsb_t;
    logic [31:0]        alu_v, lsb_v;

    assign alu_f = bus.alu_cdb_flag;
    assign alu_t = bus.alu_cdb_rob_id;
    assign alu_v = bus.alu_cdb_val;
    assign lsb_f = bus.lsb_cdb_flag;
    assign lsb_t = bus.lsb_cdb_rob_id;
    assign lsb_v = bus.lsb_cdb_val;

    // Returns {still_pending, value} after snooping both CDBs for one operand
    function automatic logic [32:0] snoop(input logic b, input logic [ROB_W-1:0] q, input logic [31:0] v);
        if (b && alu_f && q == alu_t) return {1'b0, alu_v};
        if (b && lsb_f && q == lsb_t) return {1'b0, lsb_v};
        return {b, v};
    endfunction

    assign ready       = busy & ~q1_busy & ~q2_busy;
    assign bus.rs_full = cnt == (IDX_W+1)'(RS_SIZE);
    assign disp_ok     = bus.disp_flag && !bus.rs_full;

    // The slot being issued counts as free so it can be refilled on the same edge
    always_comb begin
        iss_ok   = |ready;
        iss_idx  = '0;
        free_idx = '0;
        for (int i = RS_SIZE-1; i >= 0; i--) iss_idx = ready[i] ? IDX_W'(i) : iss_idx;
        free = ~busy;
        if (iss_ok) free[iss_idx] = 1'b1;
        for (int i = RS_SIZE-1; i >= 0; i--) free_idx = free[i] ? IDX_W'(i) : free_idx;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy          <= '0;
            cnt           <= '0;
            bus.ex_flag   <= 1'b0;
            bus.ex_v1     <= '0;
            bus.ex_v2     <= '0;
            bus.ex_a      <= '0;
            bus.ex_pc     <= '0;
            bus.ex_code   <= '0;
            bus.ex_rob_id <= '0;
        end else if (rdy) begin
            if (clr) begin
                busy        <= '0;
                cnt         <= '0;
                bus.ex_flag <= 1'b0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    {q1_busy[i], v1[i]} <= snoop(q1_busy[i], q1[i], v1[i]);
                    {q2_busy[i], v2[i]} <= snoop(q2_busy[i], q2[i], v2[i]);
                end
                bus.ex_flag <= iss_ok;
                if (iss_ok) begin
                    busy[iss_idx] <= 1'b0;
                    bus.ex_v1     <= v1[iss_idx];
                    bus.ex_v2     <= v2[iss_idx];
                    bus.ex_a      <= a[iss_idx];
                    bus.ex_pc     <= pc[iss_idx];
                    bus.ex_code   <= code[iss_idx];
                    bus.ex_rob_id <= rob_id[iss_idx];
                end
                if (disp_ok) begin
                    busy[free_idx]                  <= 1'b1;
                    code[free_idx]                  <= bus.disp_code;
                    pc[free_idx]                    <= bus.disp_pc;
                    a[free_idx]                     <= bus.disp_imm;
                    rob_id[free_idx]                <= bus.disp_rob_id;
                    q1[free_idx]                    <= bus.disp_q1;
                    q2[free_idx]                    <= bus.disp_q2;
                    {q1_busy[free_idx], v1[free_idx]} <= snoop(bus.disp_q1_busy, bus.disp_q1, bus.disp_v1);
                    {q2_busy[free_idx], v2[free_idx]} <= snoop(bus.disp_q2_busy, bus.disp_q2, bus.disp_v2);
                end
                cnt <= cnt + {{IDX_W{1'b0}}, disp_ok} - {{IDX_W{1'b0}}, iss_ok};
            end
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n) !(rdy && !clr && bus.disp_flag && bus.rs_full));
endmodule
